ram_16x8_bist: RTL

Built-in self-test engine that acts as the initiator on the 16x8 single-port RAM interface (we/re/addr/din/dout). On a start request it runs a March C- sequence over every address, compares each read against the expected background, and reports pass/fail plus first-failure diagnostics. It sits between the RAM and the test/control logic, with its RAM-side ports wired directly to the RAM's ports.

---
 rtl/ram_16x8_bist.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ram_16x8_bist.sv
// March C- built-in self-test engine for a 16x8 single-port RAM.
// Drives the RAM directly (we/re/addr/din/dout), checks every read against
// the expected background, and reports pass/fail with first-failure details.
module ram_16x8_bist #(
    parameter int                ADDR_W  = 4,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = 8'h55,
    parameter int                RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [2:0]        fail_elem,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [DATA_W-1:0] BG0       = PATTERN;
    localparam logic [DATA_W-1:0] BG1       = ~PATTERN;
    localparam logic [2:0]        LAST_ELEM = 3'd5;
    // WAIT lasts RD_LAT-1 cycles; the counter runs 0..RD_LAT-2.
    localparam logic [1:0]        WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_elem;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_wait;
    logic [7:0]          r_err_cnt;
    logic [2:0]          r_fail_elem;
    logic [ADDR_W-1:0]   r_fail_addr;
    logic [DATA_W-1:0]   r_fail_exp;
    logic [DATA_W-1:0]   r_fail_got;
    logic                r_done;
    logic                r_pass;
    logic [DATA_W-1:0]   r_din_hold;

    logic                w_busy;
    logic                w_start_ok;
    logic                w_abort;
    logic                w_desc;
    logic                w_last_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [DATA_W-1:0]   w_exp;
    logic                w_mismatch;
    logic [7:0]          w_err_next;
    logic [2:0]          w_elem_inc;
    logic                w_next_desc;
    logic [2:0]          w_step_elem;
    logic [ADDR_W-1:0]   w_step_addr;

    assign w_busy      = (r_state == S_WRITE) || (r_state == S_READ) ||
                         (r_state == S_WAIT)  || (r_state == S_CHECK);
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_abort     = abort && w_busy;

    // Elements 3 and 4 walk the address space downwards.
    assign w_desc      = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_last_addr = w_desc ? (r_addr == '0) : (r_addr == ADDR_MAX);

    // Odd elements write B1 and read B0; even elements the opposite.
    assign w_wdata     = r_elem[0] ? BG1 : BG0;
    assign w_exp       = r_elem[0] ? BG0 : BG1;

    assign w_mismatch  = (r_state == S_CHECK) && (ram_dout != w_exp);
    assign w_err_next  = (w_mismatch && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;

    // Advance to the next address, or to the first address of the next element.
    assign w_elem_inc  = r_elem + 3'd1;
    assign w_next_desc = (w_elem_inc == 3'd3) || (w_elem_inc == 3'd4);
    assign w_step_elem = w_last_addr ? w_elem_inc : r_elem;
    assign w_step_addr = w_last_addr ? (w_next_desc ? ADDR_MAX : '0)
                                     : (w_desc ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values and simulation order cannot change the result.
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode of the March sequence.
    always_comb begin
        // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next_state = S_WRITE;
            S_WRITE:        w_next_state = ((r_elem == 3'd0) && !w_last_addr) ? S_WRITE : S_READ;
            S_READ:         w_next_state = (RD_LAT == 1) ? S_CHECK : S_WAIT;
            S_WAIT:         if (r_wait == WAIT_LAST) w_next_state = S_CHECK;
            S_CHECK: begin
                if (r_elem != LAST_ELEM) begin
                    w_next_state = S_WRITE;
                end else begin
                    w_next_state = w_last_addr ? S_DONE : S_READ;
                end
            end
            default:        w_next_state = S_IDLE;
        endcase
        if (w_abort) begin
            w_next_state = S_IDLE;
        end
    end

    // Address/element sequencing, read-latency counter, result and diagnostics.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_elem      <= '0;
            r_addr      <= '0;
            r_wait      <= '0;
            r_err_cnt   <= '0;
            r_fail_elem <= '0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_din_hold  <= '0;
        end else begin
            if (r_state == S_WRITE) begin
                r_din_hold <= w_wdata;
            end
            if (w_start_ok) begin
                r_elem      <= '0;
                r_addr      <= '0;
                r_err_cnt   <= '0;
                r_fail_elem <= '0;
                r_fail_addr <= '0;
                r_fail_exp  <= '0;
                r_fail_got  <= '0;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
            end else if (!w_abort) begin
                case (r_state)
                    S_WRITE: begin
                        r_elem <= w_step_elem;
                        r_addr <= w_step_addr;
                    end
                    S_READ:  r_wait <= '0;
                    S_WAIT:  r_wait <= r_wait + 2'd1;
                    S_CHECK: begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch && (r_err_cnt == '0)) begin
                            r_fail_elem <= r_elem;
                            r_fail_addr <= r_addr;
                            r_fail_exp  <= w_exp;
                            r_fail_got  <= ram_dout;
                        end
                        if (r_elem == LAST_ELEM) begin
                            if (w_last_addr) begin
                                // Final check: its own mismatch must count toward pass.
                                r_done <= 1'b1;
                                r_pass <= (w_err_next == '0);
                            end else begin
                                r_elem <= w_step_elem;
                                r_addr <= w_step_addr;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = w_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_cnt   = r_err_cnt;
    assign fail_elem = r_fail_elem;
    assign fail_addr = r_fail_addr;
    assign fail_exp  = r_fail_exp;
    assign fail_got  = r_fail_got;
    assign ram_we    = (r_state == S_WRITE);
    assign ram_re    = (r_state == S_READ);
    assign ram_addr  = r_addr;
    assign ram_din   = ram_we ? w_wdata : r_din_hold;

endmodule
